wb_bram_ctrl: RTL

WB_BRAM_CTRL -- requirements
Module: wb_bram_ctrl

---
 rtl/wb_bram_pkg.sv | 21 ++
 rtl/wb_bram_bank.sv | 32 +++
 rtl/wb_bram_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wb_bram_pkg.sv
// Shared types and width helpers for the Wishbone block-RAM controller.
package wb_bram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    ERR
  } state_t;

  function automatic int lanes(input int data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / BYTE_W);
  endfunction

endpackage

// File: rtl/wb_bram_bank.sv
// One single-port RAM bank with per-byte write enables and a registered read port.
module wb_bram_bank
  import wb_bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WORDS  = 512,
  parameter int ROW_W  = 9
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   sel,
  input  logic [ROW_W-1:0]      row,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // NOTE: the array has no reset branch so it maps onto block RAM and keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DATA_W / BYTE_W; i++) begin
        if (we && sel[i]) begin
          mem[row][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
      rdata <= mem[row];
    end
  end

endmodule

// File: rtl/wb_bram_ctrl.sv
// Wishbone slave in front of word-interleaved block RAM banks, with programmable
// read/write wait states and error termination for addresses outside the region.
module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 10,
  parameter int          N_BANKS   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int          RD_DELAY  = 10,
  parameter int          WR_DELAY  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [DATA_W/8-1:0] wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  output logic                wbs_ack_o,
  output logic                wbs_err_o,
  output logic [DATA_W-1:0]   wbs_dat_o
);

  localparam int          LANES       = lanes(DATA_W);
  localparam int          LB          = lane_bits(DATA_W);
  localparam int          DEPTH       = 1 << ADDR_W;
  localparam int          BANK_W      = $clog2(N_BANKS);
  localparam int          BANK_BITS   = (BANK_W > 0) ? BANK_W : 1;
  localparam int          ROW_BITS    = (ADDR_W > BANK_W) ? ADDR_W - BANK_W : 1;
  localparam logic [31:0] REGION_MASK = ~(32'(DEPTH * LANES) - 32'd1);
  localparam logic [7:0]  RD_D        = 8'(RD_DELAY);
  localparam logic [7:0]  WR_D        = 8'(WR_DELAY);

  state_t              state;
  logic [7:0]          cnt;
  logic                req_we;
  logic [LANES-1:0]    req_sel;
  logic [ADDR_W-1:0]   req_index;
  logic [DATA_W-1:0]   req_dat;

  logic                accept;
  logic                in_range;
  logic                idle;
  logic                op_we;
  logic [LANES-1:0]    op_sel;
  logic [ADDR_W-1:0]   op_index;
  logic [DATA_W-1:0]   op_dat;
  logic [7:0]          op_delay;
  logic                last_wait;
  logic                go_access;
  logic [BANK_BITS-1:0] op_bank;
  logic [ROW_BITS-1:0] op_row;
  logic [BANK_BITS-1:0] rd_bank;
  logic [DATA_W-1:0]   bank_rdata [N_BANKS];

  assign accept   = wbs_cyc_i && wbs_stb_i;
  assign in_range = (wbs_adr_i & REGION_MASK) == BASE_ADDR;
  assign idle     = (state == IDLE);

  // Zero-wait transfers reach the RAM straight from the bus; otherwise the latched request is used.
  assign op_we    = idle ? wbs_we_i : req_we;
  assign op_sel   = idle ? wbs_sel_i : req_sel;
  assign op_index = idle ? wbs_adr_i[LB +: ADDR_W] : req_index;
  assign op_dat   = idle ? wbs_dat_i : req_dat;
  assign op_delay = op_we ? WR_D : RD_D;

  assign last_wait = (state == WAIT) && wbs_cyc_i && (cnt == op_delay - 8'd1);
  assign go_access = !rst && (last_wait || (idle && accept && in_range && op_delay == 8'd0));

  assign op_bank = BANK_BITS'(32'(op_index) % N_BANKS);
  assign op_row  = ROW_BITS'(32'(op_index) / N_BANKS);
  assign rd_bank = BANK_BITS'(32'(req_index) % N_BANKS);

  for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
    wb_bram_bank #(
      .DATA_W (DATA_W),
      .WORDS  (DEPTH / N_BANKS),
      .ROW_W  (ROW_BITS)
    ) u_bank (
      .clk   (clk),
      .en    (go_access && (op_bank == BANK_BITS'(g))),
      .we    (op_we),
      .sel   (op_sel),
      .row   (op_row),
      .wdata (op_dat),
      .rdata (bank_rdata[g])
    );
  end

  // NOTE: all state in this block is assigned with <= so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_we    <= wbs_we_i;
            req_sel   <= wbs_sel_i;
            req_index <= wbs_adr_i[LB +: ADDR_W];
            req_dat   <= wbs_dat_i;
            cnt       <= '0;
            if (!in_range) begin
              state     <= ERR;
              wbs_err_o <= 1'b1;
            end else if (op_delay == 8'd0) begin
              state     <= ACK;
              wbs_ack_o <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!wbs_cyc_i) begin
            state <= IDLE;
          end else if (last_wait) begin
            state     <= ACK;
            wbs_ack_o <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ACK, ERR: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign wbs_dat_o = (wbs_ack_o && !req_we) ? bank_rdata[rd_bank] : '0;

endmodule
